status_flag_unit: RTL and testbench
===================================

Name: status_flag_unit

Overview:
- Processor status (P) register and interrupt-poll front end. Sits directly downstream of the ALU.
- Captures the ALU's negative/overflow/zero/carry outputs under control-unit update strobes. Applies explicit flag ops (SEC/CLC/...), PLP/RTI loads and BIT loads.
- Feeds carry/overflow back to the ALU's carryIn/overflowIn.
- Samples NMI/IRQ at instruction boundaries and raises a pending-interrupt request to the control unit.

Parameters:
- RESET_P, 8'h24, visible P value after reset (I=1, bit5=1). Only bits 7,6,3,2,1,0 are stored.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- alu_n, alu_v, alu_z, alu_c  in  1 each  ALU flag outputs
- upd_nz  in  1  load N,Z from ALU this cycle
- upd_c  in  1  load C from ALU
- upd_v  in  1  load V from ALU
- flag_op  in  3  0 none, 1 CLC, 2 SEC, 3 CLI, 4 SEI, 5 CLV, 6 CLD, 7 SED
- bit_ld  in  1  BIT: N<=data_in[7], V<=data_in[6], Z<=alu_z
- p_ld  in  1  PLP/RTI: load P from data_in
- p_ld_rti  in  1  qualifies p_ld as RTI (I takes effect immediately)
- data_in  in  8  data bus value
- brk_push  in  1  selects B=1 in p_push
- p_out  out  8  {N,V,1,0,D,I,Z,C}
- p_push  out  8  {N,V,1,brk_push,D,I,Z,C}
- carry_out, overflow_out  out  1  to ALU carryIn/overflowIn
- nmi_n, irq_n  in  1  active-low interrupt lines, already synchronous to clk
- poll  in  1  one-cycle strobe, last cycle of each instruction
- int_req  out  1  interrupt pending, held until int_ack
- int_is_nmi  out  1  vector select, 1 = NMI ($FFFA), 0 = IRQ ($FFFE)
- int_ack  in  1  control unit has fetched the vector

Behaviour:
- Reset (sync, highest priority):
  - P <= RESET_P; i_poll <= 1.
  - nmi_prev <= 1; nmi_pend <= 0; state IDLE.
  - int_req = 0, int_is_nmi = 0; p_out = 8'h24.
  - Reset mid-sequence (ARMED) aborts to IDLE and drops any pending NMI.
- Flag update priority within one cycle:
  - p_ld wins; all other updates are ignored.
  - Else int_ack sets I=1.
  - Else per flag, flag_op wins over bit_ld, which wins over upd_* (e.g. SEC with upd_c => C=1).
  - Updates are visible on p_out one cycle after the strobe.
- p_ld ignores data_in[5:4].
- Outputs are registered-only: carry_out = C, overflow_out = V, no combinational path from alu_*.
- I-flag delay:
  - IRQ masking uses i_poll, a copy of I updated only on poll cycles, using I's value before that cycle's update.
  - Consequence: CLI/SEI/PLP change masking one instruction late.
  - p_ld with p_ld_rti also writes i_poll immediately from data_in[2].
- NMI detection: nmi_prev <= nmi_n every cycle. nmi_prev=1 && nmi_n=0 sets nmi_pend (edge-triggered; a held low level triggers once).
- State machine:
  - IDLE: on poll, if nmi_pend -> ARMED with int_is_nmi=1. Else if !irq_n && !i_poll -> ARMED with int_is_nmi=0.
  - ARMED: int_req=1. A new NMI edge while ARMED for IRQ switches int_is_nmi to 1 (hijack).
    - On int_ack: I<=1, i_poll<=1; clear nmi_pend if int_is_nmi; -> IDLE next cycle.
  - IRQ deasserting in ARMED does not cancel the request.
  - poll during ARMED is ignored.
  - An NMI edge in the same cycle as int_ack for NMI stays pending for the next poll.
- int_ack while IDLE: sets I only, no state change.

Optional Feature:
- FLAG_CMOS_DCLR_EN: when defined, D is cleared on int_ack and on reset, giving 65C02 behaviour (reset P = RESET_P & 8'hF7).
- When undefined, D is unchanged by interrupts and reset loads RESET_P exactly.

Test Plan:
- Reset, then idle -> p_out=8'h24, int_req=0, carry_out=0.
- upd_nz+upd_c with alu_n=1, alu_z=0, alu_c=1, same cycle flag_op=SEC -> next p_out=8'hA5. Then flag_op=CLC -> 8'hA4.
- irq_n=0, CLI executes, poll at end of CLI -> no int_req. Poll at end of next instruction -> int_req=1, int_is_nmi=0. int_ack -> I=1, int_req=0 next cycle.
- ARMED for IRQ, nmi_n falls -> int_is_nmi=1 before ack. After ack, nmi_pend clear; nmi_n held low for 10 cycles produces no second request.
- p_ld with data_in=8'hFF, p_ld_rti=0 -> p_out=8'hEF. A pending low irq_n is still masked at the next poll only if the prior i_poll was 1.
- brk_push=1 with P=8'h24 -> p_push=8'h34. With FLAG_CMOS_DCLR_EN, SED then int_ack -> D=0, p_out bit3=0.

Source files
------------

// File: rtl/status_flag_unit.sv
// status_flag_unit
//   Processor status (P) register plus interrupt-poll front end. Sits behind
//   the ALU: captures N/V/Z/C under update strobes, applies explicit flag ops,
//   PLP/RTI and BIT loads, feeds C/V back to the ALU, and turns NMI/IRQ into a
//   pending request sampled at instruction boundaries.
//
//   Optional build macro: FLAG_CMOS_DCLR_EN
//     defined   -> D cleared on int_ack and on reset (reset P = RESET_P & 8'hF7)
//     undefined -> D untouched by interrupts, reset loads RESET_P exactly
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   alu_n/v/z/c                 ALU flag outputs
//   upd_nz, upd_c, upd_v        capture strobes for ALU flags
//   flag_op[2:0]                0 none,1 CLC,2 SEC,3 CLI,4 SEI,5 CLV,6 CLD,7 SED
//   bit_ld                      BIT: N<=data_in[7], V<=data_in[6], Z<=alu_z
//   p_ld, p_ld_rti, data_in     PLP/RTI load of P (RTI also unmasks immediately)
//   brk_push                    B bit value for p_push
//   p_out, p_push               {N,V,1,0,D,I,Z,C} / {N,V,1,brk_push,D,I,Z,C}
//   carry_out, overflow_out     registered C / V to the ALU
//   nmi_n, irq_n                active-low interrupt lines (already synchronous)
//   poll                        last cycle of each instruction
//   int_req, int_is_nmi         pending request and vector select
//   int_ack                     control unit has fetched the vector
module status_flag_unit #(
    parameter logic [7:0] RESET_P = 8'h24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       alu_n,
    input  logic       alu_v,
    input  logic       alu_z,
    input  logic       alu_c,
    input  logic       upd_nz,
    input  logic       upd_c,
    input  logic       upd_v,
    input  logic [2:0] flag_op,
    input  logic       bit_ld,
    input  logic       p_ld,
    input  logic       p_ld_rti,
    input  logic [7:0] data_in,
    input  logic       brk_push,
    output logic [7:0] p_out,
    output logic [7:0] p_push,
    output logic       carry_out,
    output logic       overflow_out,
    input  logic       nmi_n,
    input  logic       irq_n,
    input  logic       poll,
    output logic       int_req,
    output logic       int_is_nmi,
    input  logic       int_ack
);

    localparam logic [2:0] OP_CLC = 3'd1, OP_SEC = 3'd2, OP_CLI = 3'd3,
                           OP_SEI = 3'd4, OP_CLV = 3'd5, OP_CLD = 3'd6,
                           OP_SED = 3'd7;

`ifdef FLAG_CMOS_DCLR_EN
    localparam logic [7:0] RST_P = RESET_P & 8'hF7;
`else
    localparam logic [7:0] RST_P = RESET_P;
`endif

    typedef enum logic {IDLE, ARMED} state_t;

    state_t state;
    logic   n, v, d, i, z, c;
    logic   i_poll;     // I as seen by IRQ masking, lags I by one poll
    logic   nmi_prev;
    logic   nmi_pend;
    logic   nmi_edge;

    assign nmi_edge = nmi_prev & ~nmi_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            {n, v, d, i, z, c} <= {RST_P[7:6], RST_P[3:0]};
            i_poll     <= 1'b1;
            nmi_prev   <= 1'b1;
            nmi_pend   <= 1'b0;
            state      <= IDLE;
            int_req    <= 1'b0;
            int_is_nmi <= 1'b0;
        end else begin
            nmi_prev <= nmi_n;

            // flag register: p_ld > int_ack > per-flag (flag_op > bit_ld > upd_*)
            if (p_ld) begin
                {n, v, d, i, z, c} <= {data_in[7:6], data_in[3:0]};
            end else if (int_ack) begin
                i <= 1'b1;
`ifdef FLAG_CMOS_DCLR_EN
                d <= 1'b0;
`endif
            end else begin
                if (bit_ld)      n <= data_in[7];
                else if (upd_nz) n <= alu_n;

                if (bit_ld || upd_nz) z <= alu_z;

                if (flag_op == OP_CLV) v <= 1'b0;
                else if (bit_ld)       v <= data_in[6];
                else if (upd_v)        v <= alu_v;

                if (flag_op == OP_CLC)      c <= 1'b0;
                else if (flag_op == OP_SEC) c <= 1'b1;
                else if (upd_c)             c <= alu_c;

                if (flag_op == OP_CLI)      i <= 1'b0;
                else if (flag_op == OP_SEI) i <= 1'b1;

                if (flag_op == OP_CLD)      d <= 1'b0;
                else if (flag_op == OP_SED) d <= 1'b1;
            end

            // masking copy: RTI unmasks at once, otherwise I is sampled
            // (pre-update) on each poll so CLI/SEI/PLP act one instruction late
            if (p_ld && p_ld_rti)             i_poll <= data_in[2];
            else if (int_ack && state == ARMED) i_poll <= 1'b1;
            else if (poll)                    i_poll <= i;

            // a fresh edge beats the clear, so an edge during the NMI ack
            // survives for the next poll
            if (nmi_edge)
                nmi_pend <= 1'b1;
            else if (state == ARMED && int_ack && int_is_nmi)
                nmi_pend <= 1'b0;

            case (state)
                IDLE: begin
                    if (poll) begin
                        if (nmi_pend) begin
                            state      <= ARMED;
                            int_req    <= 1'b1;
                            int_is_nmi <= 1'b1;
                        end else if (!irq_n && !i_poll) begin
                            state      <= ARMED;
                            int_req    <= 1'b1;
                            int_is_nmi <= 1'b0;
                        end
                    end
                end
                ARMED: begin
                    if (int_ack) begin
                        state      <= IDLE;
                        int_req    <= 1'b0;
                        int_is_nmi <= 1'b0;
                    end else if (nmi_edge) begin
                        int_is_nmi <= 1'b1;   // NMI hijacks a pending IRQ
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign p_out        = {n, v, 1'b1, 1'b0, d, i, z, c};
    assign p_push       = {n, v, 1'b1, brk_push, d, i, z, c};
    assign carry_out    = c;
    assign overflow_out = v;

endmodule

// File: tb/tb_status_flag_unit.sv
module tb_status_flag_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       alu_n, alu_v, alu_z, alu_c;
    logic       upd_nz, upd_c, upd_v;
    logic [2:0] flag_op;
    logic       bit_ld, p_ld, p_ld_rti;
    logic [7:0] data_in;
    logic       brk_push;
    logic [7:0] p_out, p_push;
    logic       carry_out, overflow_out;
    logic       nmi_n, irq_n, poll;
    logic       int_req, int_is_nmi, int_ack;

    int checks = 0;
    int errors = 0;

    status_flag_unit #(.RESET_P(8'h24)) dut (
        .clk(clk), .reset(reset),
        .alu_n(alu_n), .alu_v(alu_v), .alu_z(alu_z), .alu_c(alu_c),
        .upd_nz(upd_nz), .upd_c(upd_c), .upd_v(upd_v),
        .flag_op(flag_op), .bit_ld(bit_ld), .p_ld(p_ld), .p_ld_rti(p_ld_rti),
        .data_in(data_in), .brk_push(brk_push),
        .p_out(p_out), .p_push(p_push),
        .carry_out(carry_out), .overflow_out(overflow_out),
        .nmi_n(nmi_n), .irq_n(irq_n), .poll(poll),
        .int_req(int_req), .int_is_nmi(int_is_nmi), .int_ack(int_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] op;
        logic       nz, uc, uv;
        logic       an, av, az, ac;
        logic       bl, pl;
        logic [7:0] din;
        logic       ack, brk;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // strobes back to idle; interrupt lines are left alone
    task automatic clr();
        alu_n = 0; alu_v = 0; alu_z = 0; alu_c = 0;
        upd_nz = 0; upd_c = 0; upd_v = 0; flag_op = 3'd0;
        bit_ld = 0; p_ld = 0; p_ld_rti = 0; data_in = 8'h00;
        brk_push = 0; poll = 0; int_ack = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clr();
    endtask

    task automatic do_poll();
        poll = 1;
        tick();
    endtask

    task automatic do_ack();
        int_ack = 1;
        tick();
    endtask

    task automatic do_reset();
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    initial begin
        //          op    nz    uc    uv    an    av    az    ac    bl    pl    din    ack   brk   exp
        tbl[0]  = '{3'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA5};
        tbl[1]  = '{3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA4};
        tbl[2]  = '{3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hE4};
        tbl[3]  = '{3'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA4};
        tbl[4]  = '{3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hAC};
        tbl[5]  = '{3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA4};
        tbl[6]  = '{3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA0};
        tbl[7]  = '{3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'hA4};
        tbl[8]  = '{3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA0};
        tbl[9]  = '{3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA4};
        tbl[10] = '{3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h40, 1'b0, 1'b0, 8'h66};
        tbl[11] = '{3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 8'hEF};
        tbl[12] = '{3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h20};
        tbl[13] = '{3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h22};
        tbl[14] = '{3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h23};
        tbl[15] = '{3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h23};

        clr();
        nmi_n = 1; irq_n = 1;
        do_reset();

        chk("reset p_out", p_out, 8'h24);
        chk("reset int_req", {7'd0, int_req}, 8'h00);
        chk("reset int_is_nmi", {7'd0, int_is_nmi}, 8'h00);
        chk("reset carry_out", {7'd0, carry_out}, 8'h00);
        chk("reset overflow_out", {7'd0, overflow_out}, 8'h00);

        // flag update table
        for (int k = 0; k < 16; k++) begin
            logic [7:0] e;
            flag_op = tbl[k].op; upd_nz = tbl[k].nz; upd_c = tbl[k].uc; upd_v = tbl[k].uv;
            alu_n = tbl[k].an; alu_v = tbl[k].av; alu_z = tbl[k].az; alu_c = tbl[k].ac;
            bit_ld = tbl[k].bl; p_ld = tbl[k].pl; data_in = tbl[k].din; int_ack = tbl[k].ack;
            @(posedge clk);
            #1;
            brk_push = tbl[k].brk;
            #1;
            e = tbl[k].exp;
            chk($sformatf("vec%0d p_out", k), p_out, e);
            chk($sformatf("vec%0d p_push", k), p_push, tbl[k].brk ? (e | 8'h10) : e);
            chk($sformatf("vec%0d carry_out", k), {7'd0, carry_out}, {7'd0, e[0]});
            chk($sformatf("vec%0d overflow_out", k), {7'd0, overflow_out}, {7'd0, e[6]});
            clr();
        end

        do_reset();
        brk_push = 1;
        #1;
        chk("brk p_push", p_push, 8'h34);
        clr();

        // CLI latency: masked at CLI's own poll, taken at the next one
        irq_n = 0;
        flag_op = 3'd3; tick();
        do_poll();
        chk("cli poll int_req", {7'd0, int_req}, 8'h00);
        tick();
        do_poll();
        chk("next poll int_req", {7'd0, int_req}, 8'h01);
        chk("next poll int_is_nmi", {7'd0, int_is_nmi}, 8'h00);
        irq_n = 1;
        tick();
        do_poll();
        chk("irq drop keeps req", {7'd0, int_req}, 8'h01);
        do_ack();
        chk("ack int_req", {7'd0, int_req}, 8'h00);
        chk("ack sets I", p_out, 8'h24);

        // NMI hijacks a pending IRQ
        irq_n = 0;
        flag_op = 3'd3; tick();
        do_poll();
        do_poll();
        chk("irq armed", {6'd0, int_req, int_is_nmi}, 8'h02);
        nmi_n = 0; tick();
        chk("hijack", {6'd0, int_req, int_is_nmi}, 8'h03);
        irq_n = 1;
        do_ack();
        chk("hijack ack", {6'd0, int_req, int_is_nmi}, 8'h00);
        begin
            logic any_req = 1'b0;
            for (int k = 0; k < 10; k++) begin
                poll = k[0];
                tick();
                any_req |= int_req;
            end
            chk("held nmi no retrigger", {7'd0, any_req}, 8'h00);
        end

        // NMI edge coincident with its own ack stays pending
        nmi_n = 1; tick();
        nmi_n = 0; tick();
        do_poll();
        chk("nmi armed", {6'd0, int_req, int_is_nmi}, 8'h03);
        nmi_n = 1; tick();
        nmi_n = 0; int_ack = 1; tick();
        chk("ack with edge", {7'd0, int_req}, 8'h00);
        do_poll();
        chk("edge kept pending", {6'd0, int_req, int_is_nmi}, 8'h03);
        do_ack();
        nmi_n = 1; tick();

        // PLP (no RTI) unmasks one poll late; RTI unmasks at once
        irq_n = 0;
        p_ld = 1; data_in = 8'hFB; tick();
        chk("plp p_out", p_out, 8'hEB);
        do_poll();
        chk("plp masked poll", {7'd0, int_req}, 8'h00);
        do_poll();
        chk("plp late irq", {6'd0, int_req, int_is_nmi}, 8'h02);
        do_ack();
        chk("plp ack p_out", p_out, 8'hEF);
        p_ld = 1; p_ld_rti = 1; data_in = 8'hFB; tick();
        do_poll();
        chk("rti immediate irq", {6'd0, int_req, int_is_nmi}, 8'h02);
        do_ack();
        irq_n = 1;

        // reset while ARMED aborts and drops the pending NMI
        nmi_n = 0; tick();
        do_poll();
        chk("pre-reset armed", {6'd0, int_req, int_is_nmi}, 8'h03);
        nmi_n = 1;
        do_reset();
        chk("reset aborts req", {6'd0, int_req, int_is_nmi}, 8'h00);
        chk("reset p_out again", p_out, 8'h24);
        do_poll();
        chk("nmi dropped by reset", {7'd0, int_req}, 8'h00);

`ifdef FLAG_CMOS_DCLR_EN
        flag_op = 3'd7; tick();
        chk("cmos sed", p_out, 8'h2C);
        do_ack();
        chk("cmos ack clears D", p_out, 8'h24);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
